prog_loader_xlen: RTL

Parametrised program loader that writes a short RISC-V test program into instruction memory before the core is released from reset. It loads two operands of up to 32 bits into registers, then issues one of ten R-type ALU operations, then a halt loop. The write port supports memory backpressure, and a start/busy/done handshake controls the block. It sits between the test-control logic and the imem write port. Operands that do not fit a 12-bit signed immediate are loaded with a LUI+ADDI pair.

---
 rtl/prog_loader_xlen.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/prog_loader_xlen.sv
// -----------------------------------------------------------------------------
// prog_loader_xlen
//
// Writes a short RISC-V test program into instruction memory while the core is
// held in reset. The program loads two operands into registers RS1/RS2 (one
// ADDI when the value fits a 12-bit signed immediate, otherwise LUI+ADDI),
// issues one R-type ALU instruction into RD, and finishes with a JAL x0,0 halt
// loop. Each word is held on the write port until the memory accepts it.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset (aborts a load in progress)
//   start       one-cycle load request, sampled only while idle
//   op1, op2    operands, DATA_W bits, zero-extended to 32 bits
//   alu_op      0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLT,6 SLTU,7 SLL,8 SRL,9 SRA
//   imem_ready  memory accepts the presented word this cycle
//   imem_we     write request
//   imem_addr   byte address of the presented word
//   imem_wdata  presented instruction word
//   busy        a load is in progress
//   done        last load completed; held until the next accepted start
//   err         last load used an unsupported alu_op; held likewise
//   prog_len    words accepted so far in the last/current load
// -----------------------------------------------------------------------------
module prog_loader_xlen #(
  parameter int          DATA_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          RS1       = 9,
  parameter int          RS2       = 10,
  parameter int          RD        = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic [3:0]        alu_op,
  input  logic              imem_ready,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        prog_len
);

  localparam logic [4:0]  R1     = RS1[4:0];
  localparam logic [4:0]  R2     = RS2[4:0];
  localparam logic [4:0]  RDST   = RD[4:0];
  localparam logic [6:0]  OPC_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_LUI = 7'b0110111;
  localparam logic [6:0]  OPC_REG = 7'b0110011;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
  localparam logic [31:0] HALT_WORD = 32'h0000_006F;

  typedef enum logic [2:0] {
    IDLE,
    OP1_HI,
    OP1_LO,
    OP2_HI,
    OP2_LO,
    ALU,
    HALT
  } state_t;

  // ---------------------------------------------------------------------------
  // Instruction encoders
  // ---------------------------------------------------------------------------

  // A value is reachable by a single ADDI from x0 when its upper 21 bits are a
  // sign extension of bit 11.
  function automatic logic fits_imm12(input logic [31:0] v);
    return (v[31:11] == '0) || (v[31:11] == '1);
  endfunction

  // The +0x800 pre-rounds the upper part so the following sign-extended ADDI
  // lands on the exact value.
  function automatic logic [31:0] lui_word(input logic [31:0] v,
                                           input logic [4:0]  r);
    logic [31:0] rounded;
    rounded = v + 32'h0000_0800;
    return {rounded[31:12], r, OPC_LUI};
  endfunction

  // Second half of a pair adds into the same register; a lone ADDI uses x0.
  function automatic logic [31:0] addi_word(input logic [31:0] v,
                                            input logic [4:0]  r,
                                            input logic        pair);
    logic [4:0] src;
    src = pair ? r : 5'd0;
    return {v[11:0], src, 3'b000, r, OPC_IMM};
  endfunction

  // Returns {unsupported, word}.
  function automatic logic [32:0] alu_word(input logic [3:0] op);
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       bad;
    funct7 = 7'h00;
    funct3 = 3'b000;
    bad    = 1'b0;
    case (op)
      4'd0:    begin funct7 = 7'h00; funct3 = 3'b000; end
      4'd1:    begin funct7 = 7'h20; funct3 = 3'b000; end
      4'd2:    begin funct7 = 7'h00; funct3 = 3'b111; end
      4'd3:    begin funct7 = 7'h00; funct3 = 3'b110; end
      4'd4:    begin funct7 = 7'h00; funct3 = 3'b100; end
      4'd5:    begin funct7 = 7'h00; funct3 = 3'b010; end
      4'd6:    begin funct7 = 7'h00; funct3 = 3'b011; end
      4'd7:    begin funct7 = 7'h00; funct3 = 3'b001; end
      4'd8:    begin funct7 = 7'h00; funct3 = 3'b101; end
      4'd9:    begin funct7 = 7'h20; funct3 = 3'b101; end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      return {1'b1, NOP_WORD};
    end
    return {1'b0, funct7, R2, R1, funct3, RDST, OPC_REG};
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [31:0] v1_q, v2_q;
  logic [3:0]  alu_op_q;
  logic [31:0] addr_q;
  logic        busy_q, done_q, err_q;
  logic [2:0]  len_q;

  logic [31:0] op1_ext, op2_ext;
  logic        we;
  logic [31:0] wdata;
  logic        alu_bad;
  logic        accept;
  logic        take_start;

  always_comb begin
    op1_ext             = '0;
    op2_ext             = '0;
    op1_ext[DATA_W-1:0] = op1;
    op2_ext[DATA_W-1:0] = op2;
  end

  assign take_start = (state_q == IDLE) && start;
  assign accept     = we && imem_ready;

  // ---------------------------------------------------------------------------
  // Next-state and write-port decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    we      = 1'b0;
    wdata   = '0;
    alu_bad = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = fits_imm12(op1_ext) ? OP1_LO : OP1_HI;
        end
      end

      OP1_HI: begin
        we    = 1'b1;
        wdata = lui_word(v1_q, R1);
        if (imem_ready) state_d = OP1_LO;
      end

      OP1_LO: begin
        we    = 1'b1;
        wdata = addi_word(v1_q, R1, !fits_imm12(v1_q));
        if (imem_ready) state_d = fits_imm12(v2_q) ? OP2_LO : OP2_HI;
      end

      OP2_HI: begin
        we    = 1'b1;
        wdata = lui_word(v2_q, R2);
        if (imem_ready) state_d = OP2_LO;
      end

      OP2_LO: begin
        we    = 1'b1;
        wdata = addi_word(v2_q, R2, !fits_imm12(v2_q));
        if (imem_ready) state_d = ALU;
      end

      ALU: begin
        we               = 1'b1;
        {alu_bad, wdata} = alu_word(alu_op_q);
        if (imem_ready) state_d = HALT;
      end

      HALT: begin
        we    = 1'b1;
        wdata = HALT_WORD;
        if (imem_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments so every register samples pre-edge values
  // regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      v1_q     <= '0;
      v2_q     <= '0;
      alu_op_q <= '0;
      addr_q   <= BASE_ADDR;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      len_q    <= '0;
    end else begin
      state_q <= state_d;

      if (take_start) begin
        v1_q     <= op1_ext;
        v2_q     <= op2_ext;
        alu_op_q <= alu_op;
        addr_q   <= BASE_ADDR;
        busy_q   <= 1'b1;
        done_q   <= 1'b0;
        err_q    <= 1'b0;
        len_q    <= '0;
      end

      // Accept only happens outside IDLE, so it never collides with a start.
      if (accept) begin
        addr_q <= addr_q + 32'd4;
        len_q  <= len_q + 3'd1;
        if (alu_bad) err_q <= 1'b1;
        if (state_q == HALT) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign imem_we    = we;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign prog_len   = len_q;

endmodule
